// File: rtl/rom_addr_gen_pkg.sv
// Shared types for the multi-channel ROM address generator.
package rom_addr_gen_pkg;

    // Widest step the config record can carry; the top uses the low ACC_W bits.
    localparam int unsigned CFG_STEP_W = 32;

    typedef enum logic {
        MODE_SAW = 1'b0,
        MODE_TRI = 1'b1
    } mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_e;

    typedef struct packed {
        logic [CFG_STEP_W-1:0] step;
        mode_e                 mode;
        logic                  en;
    } ch_cfg_t;

    function automatic int unsigned ch_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rom_addr_phase_acc.sv
// Combinational next-accumulator, next-direction and wrap for one channel.
module rom_addr_phase_acc
    import rom_addr_gen_pkg::*;
#(
    parameter int unsigned ACC_W = 16
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [ACC_W-1:0] step,
    input  mode_e            mode,
    input  logic             dir,
    output logic [ACC_W-1:0] acc_nxt_c,
    output logic             dir_nxt_c,
    output logic             wrap_c
);

    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    logic [ACC_W:0] sum_c;

    assign sum_c = {1'b0, acc} + {1'b0, step};

    // dir: 0 = counting up, 1 = counting down; a zero step never moves or wraps
    always_comb begin
        acc_nxt_c = acc;
        dir_nxt_c = dir;
        wrap_c    = 1'b0;
        if (step != '0) begin
            if (mode == MODE_SAW) begin
                acc_nxt_c = sum_c[ACC_W-1:0];
                wrap_c    = sum_c[ACC_W];
            end else if (!dir) begin
                if (sum_c >= {1'b0, ACC_MAX}) begin
                    acc_nxt_c = ACC_MAX;
                    dir_nxt_c = 1'b1;
                    wrap_c    = 1'b1;
                end else begin
                    acc_nxt_c = sum_c[ACC_W-1:0];
                end
            end else begin
                if (acc <= step) begin
                    acc_nxt_c = '0;
                    dir_nxt_c = 1'b0;
                    wrap_c    = 1'b1;
                end else begin
                    acc_nxt_c = acc - step;
                end
            end
        end
    end

endmodule

// File: rtl/rom_addr_gen_multi.sv
// Multi-channel SAW/TRI ROM address generator, one address per channel per sample_tick.
// Optional ROM_ADDR_PHASE_OFS_EN adds a per-channel address offset.
module rom_addr_gen_multi
    import rom_addr_gen_pkg::*;
#(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned ACC_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sample_tick,
    input  logic                      phase_clr,
    input  logic                      cfg_wr,
    input  logic [ch_w(NUM_CH)-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]          cfg_step,
    input  logic                      cfg_mode,
    input  logic                      cfg_en,
    output logic [ADDR_W-1:0]         addr,
    output logic [ch_w(NUM_CH)-1:0]   addr_ch,
    output logic                      addr_valid,
    output logic                      wrap,
    output logic                      overrun
);

    localparam int unsigned CH_W    = ch_w(NUM_CH);
    localparam int unsigned FRAC_W  = ACC_W - ADDR_W;
    localparam int unsigned LAST_CH = NUM_CH - 1;

    state_e            state_q, state_d;
    logic [CH_W-1:0]   idx_q, idx_d;
    logic [ACC_W-1:0]  acc_q [NUM_CH];
    logic [ACC_W-1:0]  acc_d [NUM_CH];
    logic              dir_q [NUM_CH];
    logic              dir_d [NUM_CH];
    ch_cfg_t           cfg_q [NUM_CH];
    ch_cfg_t           cfg_d [NUM_CH];
`ifdef ROM_ADDR_PHASE_OFS_EN
    logic [ADDR_W-1:0] offset_q [NUM_CH];
    logic [ADDR_W-1:0] offset_d [NUM_CH];
`endif
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CH_W-1:0]   addr_ch_q, addr_ch_d;
    logic              addr_valid_q, addr_valid_d;
    logic              wrap_q, wrap_d;
    logic              overrun_q, overrun_d;

    logic              emit_c;
    logic [CH_W-1:0]   sel_c;
    logic [ACC_W-1:0]  pa_acc_nxt;
    logic              pa_dir_nxt;
    logic              pa_wrap;

    // Sweep control: emit_c/sel_c name the channel emitted and updated at the coming edge
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        overrun_d = overrun_q;
        emit_c    = 1'b0;
        sel_c     = '0;
        case (state_q)
            ST_IDLE: begin
                if (sample_tick) begin
                    emit_c  = 1'b1;
                    state_d = ST_SWEEP;
                    idx_d   = '0;
                end
            end
            ST_SWEEP: begin
                if (sample_tick) begin
                    overrun_d = 1'b1;
                end
                if (idx_q == CH_W'(LAST_CH)) begin
                    state_d = ST_IDLE;
                end else begin
                    emit_c = 1'b1;
                    sel_c  = idx_q + CH_W'(1);
                    idx_d  = idx_q + CH_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    rom_addr_phase_acc #(
        .ACC_W (ACC_W)
    ) u_phase_acc (
        .acc       (acc_q[sel_c]),
        .step      (ACC_W'(cfg_q[sel_c].step)),
        .mode      (cfg_q[sel_c].mode),
        .dir       (dir_q[sel_c]),
        .acc_nxt_c (pa_acc_nxt),
        .dir_nxt_c (pa_dir_nxt),
        .wrap_c    (pa_wrap)
    );

    // Datapath: emit pre-update address, then update; phase_clr overrides the update
    always_comb begin
        acc_d        = acc_q;
        dir_d        = dir_q;
        cfg_d        = cfg_q;
`ifdef ROM_ADDR_PHASE_OFS_EN
        offset_d     = offset_q;
`endif
        addr_d       = addr_q;
        addr_ch_d    = addr_ch_q;
        addr_valid_d = emit_c;
        wrap_d       = 1'b0;
        if (emit_c) begin
`ifdef ROM_ADDR_PHASE_OFS_EN
            addr_d = acc_q[sel_c][ACC_W-1 -: ADDR_W] + offset_q[sel_c];
`else
            addr_d = acc_q[sel_c][ACC_W-1 -: ADDR_W];
`endif
            addr_ch_d = sel_c;
            if (cfg_q[sel_c].en && !phase_clr) begin
                acc_d[sel_c] = pa_acc_nxt;
                dir_d[sel_c] = pa_dir_nxt;
                wrap_d       = pa_wrap;
            end
        end
        if (phase_clr) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                acc_d[i] = '0;
                dir_d[i] = 1'b0;
            end
        end
        if (cfg_wr) begin
            cfg_d[cfg_ch].step = CFG_STEP_W'(cfg_step);
            cfg_d[cfg_ch].mode = mode_e'(cfg_mode);
            cfg_d[cfg_ch].en   = cfg_en;
`ifdef ROM_ADDR_PHASE_OFS_EN
            offset_d[cfg_ch]   = cfg_step[ADDR_W-1:0];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            addr_q       <= '0;
            addr_ch_q    <= '0;
            addr_valid_q <= 1'b0;
            wrap_q       <= 1'b0;
            overrun_q    <= 1'b0;
            for (int i = 0; i < int'(NUM_CH); i++) begin
                acc_q[i] <= '0;
                dir_q[i] <= 1'b0;
                cfg_q[i] <= '{step: CFG_STEP_W'((i + 1) << FRAC_W), mode: MODE_SAW, en: 1'b1};
`ifdef ROM_ADDR_PHASE_OFS_EN
                offset_q[i] <= ADDR_W'((i * (1 << ADDR_W)) / int'(NUM_CH));
`endif
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            addr_q       <= addr_d;
            addr_ch_q    <= addr_ch_d;
            addr_valid_q <= addr_valid_d;
            wrap_q       <= wrap_d;
            overrun_q    <= overrun_d;
            acc_q        <= acc_d;
            dir_q        <= dir_d;
            cfg_q        <= cfg_d;
`ifdef ROM_ADDR_PHASE_OFS_EN
            offset_q     <= offset_d;
`endif
        end
    end

    assign addr       = addr_q;
    assign addr_ch    = addr_ch_q;
    assign addr_valid = addr_valid_q;
    assign wrap       = wrap_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_rom_addr_gen_multi.sv
// Bench for rom_addr_gen_multi: directed scenarios plus randomized sweeps against a sweep-level model.
module tb_rom_addr_gen_multi;

    localparam int unsigned NUM_CH = 2;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned ACC_W  = 16;
    localparam int unsigned CH_W   = 1;
    localparam int unsigned FRAC_W = ACC_W - ADDR_W;
    localparam int ACC_M  = 1 << ACC_W;
    localparam int ADDR_M = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              sample_tick = 1'b0;
    logic              phase_clr = 1'b0;
    logic              cfg_wr = 1'b0;
    logic [CH_W-1:0]   cfg_ch = '0;
    logic [ACC_W-1:0]  cfg_step = '0;
    logic              cfg_mode = 1'b0;
    logic              cfg_en = 1'b0;
    logic [ADDR_W-1:0] addr;
    logic [CH_W-1:0]   addr_ch;
    logic              addr_valid;
    logic              wrap;
    logic              overrun;

    int total = 0;
    int bad   = 0;

    // reference model state
    int m_acc [NUM_CH];
    int m_step[NUM_CH];
    int m_off [NUM_CH];
    bit m_tri [NUM_CH];
    bit m_down[NUM_CH];
    bit m_en  [NUM_CH];
    bit m_ovr;

    int hist0[$];
    int hwrap0[$];
    int hist1[$];

    // pending config write used by cfg_idle and sweep
    int w_ch, w_step;
    bit w_mode, w_en;

    rom_addr_gen_multi #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .sample_tick(sample_tick), .phase_clr(phase_clr),
        .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_step(cfg_step), .cfg_mode(cfg_mode),
        .cfg_en(cfg_en), .addr(addr), .addr_ch(addr_ch), .addr_valid(addr_valid),
        .wrap(wrap), .overrun(overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < int'(NUM_CH); i++) begin
            m_acc[i]  = 0;
            m_down[i] = 1'b0;
            m_tri[i]  = 1'b0;
            m_en[i]   = 1'b1;
            m_step[i] = (i + 1) << FRAC_W;
`ifdef ROM_ADDR_PHASE_OFS_EN
            m_off[i]  = i * ADDR_M / int'(NUM_CH);
`else
            m_off[i]  = 0;
`endif
        end
        m_ovr = 1'b0;
    endtask

    task automatic m_clear();
        for (int i = 0; i < int'(NUM_CH); i++) begin
            m_acc[i]  = 0;
            m_down[i] = 1'b0;
        end
    endtask

    task automatic m_cfg(input int ch, input int step, input bit mode, input bit en);
        m_step[ch] = step;
        m_tri[ch]  = mode;
        m_en[ch]   = en;
`ifdef ROM_ADDR_PHASE_OFS_EN
        m_off[ch]  = step % ADDR_M;
`endif
    endtask

    // Address seen for channel ch this sweep, then the phase advance by the SAW/TRI rules
    task automatic m_emit(input int ch, input bit hold, output int ea, output bit ew);
        int a, s;
        a  = m_acc[ch];
        s  = m_step[ch];
        ea = (a / (1 << FRAC_W) + m_off[ch]) % ADDR_M;
        ew = 1'b0;
        if (m_en[ch] && !hold && s != 0) begin
            if (!m_tri[ch]) begin
                ew = (a + s) >= ACC_M;
                m_acc[ch] = (a + s) % ACC_M;
            end else if (!m_down[ch]) begin
                if (a + s >= ACC_M - 1) begin
                    m_acc[ch] = ACC_M - 1; m_down[ch] = 1'b1; ew = 1'b1;
                end else begin
                    m_acc[ch] = a + s;
                end
            end else begin
                if (a <= s) begin
                    m_acc[ch] = 0; m_down[ch] = 1'b0; ew = 1'b1;
                end else begin
                    m_acc[ch] = a - s;
                end
            end
        end
    endtask

    task automatic drive_cfg();
        cfg_ch   = CH_W'(w_ch);
        cfg_step = ACC_W'(w_step);
        cfg_mode = w_mode;
        cfg_en   = w_en;
    endtask

    task automatic cfg_idle();
        drive_cfg();
        cfg_wr = 1'b1;
        cyc();
        cfg_wr = 1'b0;
        m_cfg(w_ch, w_step, w_mode, w_en);
    endtask

    task automatic clr_idle();
        phase_clr = 1'b1;
        cyc();
        phase_clr = 1'b0;
        m_clear();
    endtask

    // Cycle c=0 carries the tick; extra strobes land on the cycles given (-1 = none)
    task automatic sweep(input int tick_at, input int clr_at, input int cfgw_at);
        int ea;
        bit ew;
        for (int c = 0; c <= int'(NUM_CH); c++) begin
            sample_tick = (c == 0) || (c == tick_at);
            phase_clr   = (c == clr_at);
            cfg_wr      = (c == cfgw_at);
            drive_cfg();
            cyc();
            if (c < int'(NUM_CH)) begin
                m_emit(c, c == clr_at, ea, ew);
                chk("valid", 32'(addr_valid), 32'(1));
                chk("addr_ch", 32'(addr_ch), 32'(c));
                chk("addr", 32'(addr), 32'(ea));
                chk("wrap", 32'(wrap), 32'(ew));
                if (c == 0) begin
                    hist0.push_back(int'(addr));
                    hwrap0.push_back(int'(wrap));
                end
                if (c == 1) hist1.push_back(int'(addr));
            end else begin
                chk("valid_end", 32'(addr_valid), 32'(0));
            end
            if (c == clr_at) m_clear();
            if (c == cfgw_at) m_cfg(w_ch, w_step, w_mode, w_en);
            if (c > 0 && c == tick_at) m_ovr = 1'b1;
            chk("overrun", 32'(overrun), 32'(m_ovr));
        end
        sample_tick = 1'b0;
        phase_clr   = 1'b0;
        cfg_wr      = 1'b0;
    endtask

    function automatic int rnd_step();
        case ($urandom_range(0, 3))
            0: return 0;
            1: return int'($urandom_range(1, 32'h300));
            2: return int'($urandom_range(0, 32'hFFFF));
            default: return 32'hFFFF;
        endcase
    endfunction

    task automatic rnd_cfg();
        w_ch   = int'($urandom_range(0, NUM_CH - 1));
        w_step = rnd_step();
        w_mode = 1'($urandom_range(0, 1));
        w_en   = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        m_reset();
        w_ch = 0; w_step = 0; w_mode = 1'b0; w_en = 1'b1;
        repeat (3) cyc();
        chk("rst_addr", 32'(addr), 32'(0));
        chk("rst_addr_ch", 32'(addr_ch), 32'(0));
        chk("rst_valid", 32'(addr_valid), 32'(0));
        chk("rst_wrap", 32'(wrap), 32'(0));
        chk("rst_overrun", 32'(overrun), 32'(0));
        rst = 1'b0;
        cyc();

        // defaults: three ticks
        hist0.delete(); hist1.delete();
        repeat (3) sweep(-1, -1, -1);
`ifndef ROM_ADDR_PHASE_OFS_EN
        chk("t1_ch0_third", 32'(hist0[2]), 32'(2));
        chk("t1_ch1_third", 32'(hist1[2]), 32'(4));
`endif

        // SAW step 0x0100 up to 0xFF00 and across the carry
        clr_idle();
        w_ch = 0; w_step = 32'h0100; w_mode = 1'b0; w_en = 1'b1;
        cfg_idle();
        hist0.delete(); hwrap0.delete();
        repeat (257) sweep(-1, -1, -1);
        chk("t2_addr_ff", 32'(hist0[255]), 32'hFF);
        chk("t2_wrap", 32'(hwrap0[255]), 32'(1));
        chk("t2_addr_00", 32'(hist0[256]), 32'h00);

        // TRI step 0x4000 ping-pong
        clr_idle();
        w_ch = 0; w_step = 32'h4000; w_mode = 1'b1; w_en = 1'b1;
        cfg_idle();
        hist0.delete(); hwrap0.delete();
        repeat (12) sweep(-1, -1, -1);
        chk("t3_turn_up", 32'(hist0[3]), 32'hC0);
        chk("t3_turn_up_wrap", 32'(hwrap0[3]), 32'(1));
        chk("t3_top", 32'(hist0[4]), 32'hFF);
        chk("t3_turn_dn_wrap", 32'(hwrap0[7]), 32'(1));
        chk("t3_bottom", 32'(hist0[8]), 32'h00);

        // tick during the sweep: ignored, sticky overrun
        sweep(2, -1, -1);
        cyc();
        chk("t4_no_extra_sweep", 32'(addr_valid), 32'(0));
        sweep(1, -1, -1);
        chk("t4_sticky", 32'(overrun), 32'(1));

        // same-cycle config write uses the old step, then ch0 holds
        w_ch = 0; w_step = 32'h0300; w_mode = 1'b0; w_en = 1'b1;
        cfg_idle();
        w_step = 0;
        sweep(-1, -1, 0);
        repeat (2) sweep(-1, -1, -1);
        sweep(-1, 1, -1);
        sweep(-1, -1, -1);

        // randomized config, mid-sweep strobes
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                rnd_cfg();
                cfg_idle();
            end
            if ($urandom_range(0, 7) == 0) clr_idle();
            rnd_cfg();
            sweep(int'($urandom_range(0, 3)) - 1, int'($urandom_range(0, 4)) - 1,
                  int'($urandom_range(0, 3)) - 1);
        end

        // reset in the middle of a sweep
        sample_tick = 1'b1;
        cyc();
        sample_tick = 1'b0;
        rst = 1'b1;
        cyc();
        chk("rst_mid_valid", 32'(addr_valid), 32'(0));
        chk("rst_mid_overrun", 32'(overrun), 32'(0));
        chk("rst_mid_addr", 32'(addr), 32'(0));
        rst = 1'b0;
        m_reset();
        cyc();
        hist0.delete(); hist1.delete();
        sweep(-1, -1, -1);
`ifdef ROM_ADDR_PHASE_OFS_EN
        chk("t6_ch1_ofs", 32'(hist1[0]), 32'h80);
        clr_idle();
        w_ch = 0; w_step = 32'h20F0; w_mode = 1'b0; w_en = 1'b1;
        cfg_idle();
        hist0.delete();
        repeat (2) sweep(-1, -1, -1);
        chk("t6_ofs_wrap", 32'(hist0[1]), 32'h10);
`else
        chk("t6_ch1_plain", 32'(hist1[0]), 32'h00);
`endif
        repeat (4) sweep(-1, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
